// File: rtl/sw_seq_driver.sv
// Stimulus/self-test initiator for the 3-bit switch-code LED FSM: walks the full
// or shortcut code path, checks the led feedback for each step, reports done/error.
module sw_seq_driver #(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       path_sel,
    input  logic [2:0] led_fb,
    output logic [2:0] sw,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] step
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRIVE    = 3'd1,
        WAIT_ACK = 3'd2,
        GAP      = 3'd3,
        DONE     = 3'd4,
        ERR      = 3'd5
    } state_t;

    state_t            state;
    logic              path;
    logic [CNT_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]  to_cnt;

    function automatic logic [2:0] code_of(input logic p, input logic [2:0] s);
        logic [2:0] c;
        c = 3'b000;
        if (!p) begin
            c = s + 3'd1;
        end else begin
            case (s)
                3'd0:    c = 3'b111;
                3'd1:    c = 3'b100;
                3'd2:    c = 3'b101;
                default: c = 3'b110;
            endcase
        end
        return c;
    endfunction

    function automatic logic [2:0] exp_of(input logic p, input logic [2:0] s);
        logic [2:0] e;
        e = 3'b000;
        if (!p) begin
            case (s)
                3'd0:    e = 3'b001;
                3'd1:    e = 3'b010;
                3'd2:    e = 3'b011;
                3'd3:    e = 3'b100;
                3'd4:    e = 3'b111;
                default: e = 3'b000;
            endcase
        end else begin
            case (s)
                3'd0:    e = 3'b011;
                3'd1:    e = 3'b100;
                3'd2:    e = 3'b111;
                default: e = 3'b000;
            endcase
        end
        return e;
    endfunction

    function automatic logic [2:0] last_of(input logic p);
        return p ? 3'd3 : 3'd5;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            path     <= 1'b0;
            hold_cnt <= '0;
            to_cnt   <= '0;
            sw       <= 3'b000;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            step     <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    sw   <= 3'b000;
                    busy <= 1'b0;
                    if (start) begin
                        path     <= path_sel;
                        step     <= 3'd0;
                        hold_cnt <= '0;
                        to_cnt   <= '0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        sw       <= code_of(path_sel, 3'd0);
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                    if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        to_cnt <= '0;
                        state  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // A match takes priority over an expiring timeout in the same cycle.
                    if (led_fb == exp_of(path, step)) begin
                        sw    <= 3'b000;
                        state <= GAP;
                    end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        sw    <= 3'b000;
                        busy  <= 1'b0;
                        error <= 1'b1;
                        state <= ERR;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (step == last_of(path)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        step     <= step + 3'd1;
                        hold_cnt <= '0;
                        sw       <= code_of(path, step + 3'd1);
                        state    <= DRIVE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    path     <= 1'b0;
                    hold_cnt <= '0;
                    to_cnt   <= '0;
                    sw       <= 3'b000;
                    busy     <= 1'b0;
                    error    <= 1'b0;
                    step     <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_seq_driver.sv
// Bench for sw_seq_driver: a latency-configurable LED-FSM responder plus a
// timeline model computed per run from hold/wait/gap arithmetic.
module tb_sw_seq_driver;

    localparam int H = 4;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       path_sel = 1'b0;
    logic [2:0] led_fb;
    logic [2:0] sw;
    logic       busy, done, error;
    logic [2:0] step;

    sw_seq_driver #(.HOLD_CYCLES(H), .TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .path_sel(path_sel),
        .led_fb(led_fb), .sw(sw), .busy(busy), .done(done), .error(error),
        .step(step)
    );

    always #5 clk = ~clk;

    // Target FSM stand-in: led follows the last non-zero code, delayed by lat cycles.
    logic       resp_clr = 1'b0;
    logic       stuck = 1'b0;
    logic [4:0] lat_idx = 5'd0;
    logic [2:0] pipe [32];

    function automatic logic [2:0] led_map(input logic [2:0] c);
        case (c)
            3'b001:  return 3'b001;
            3'b010:  return 3'b010;
            3'b011:  return 3'b011;
            3'b100:  return 3'b100;
            3'b101:  return 3'b111;
            3'b111:  return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (resp_clr) begin
            for (int i = 0; i < 32; i++) pipe[i] <= 3'b000;
        end else begin
            pipe[0] <= (sw != 3'b000) ? led_map(sw) : pipe[0];
            for (int i = 1; i < 32; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign led_fb = stuck ? 3'b000 : pipe[lat_idx];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int r, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s r=%0d got {sw,busy,done,err,step}=%b want=%b", nm, r, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] tb_code(input bit p, input int s);
        if (!p) return 3'(s + 1);
        case (s)
            0:       return 3'b111;
            1:       return 3'b100;
            2:       return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    function automatic logic [10:0] outs();
        return {sw, busy, done, error, step};
    endfunction

    task automatic prep(input bit stk, input int lat);
        @(negedge clk);
        stuck    = stk;
        lat_idx  = 5'(lat - 1);
        resp_clr = 1'b1;
        @(negedge clk);
        resp_clr = 1'b0;
    endtask

    // One run: cycle r is the r-th cycle after the edge that accepts start.
    task automatic run(input string nm, input bit p, input bit stk, input int lat, input int mid_r,
                       input int exp_done, input int exp_err, input int exp_step);
        int w, per, n, d_cyc, e_cyc, end_r, obs_done, obs_err, n_done, s, o;
        bit is_err;
        logic [10:0] e;
        n      = p ? 4 : 6;
        w      = stk ? T : ((lat > H) ? lat - H : 0);
        is_err = (w >= T);
        per    = H + w + 2;
        d_cyc  = 1 + n * per;
        e_cyc  = 1 + H + T;
        end_r  = (is_err ? e_cyc : d_cyc) + 3;
        obs_done = -1; obs_err = -1; n_done = 0;
        prep(stk, lat);
        start = 1'b1; path_sel = p;
        @(negedge clk);
        start = 1'b0; path_sel = ~p;
        for (int r = 1; r <= end_r; r++) begin
            start = 1'b0;
            if (is_err) begin
                if (r < e_cyc) e = {tb_code(p, 0), 1'b1, 1'b0, 1'b0, 3'd0};
                else           e = {3'b000, 1'b0, 1'b0, 1'b1, 3'd0};
            end else begin
                if (r < d_cyc) begin
                    s = (r - 1) / per;
                    o = (r - 1) % per;
                    e = {(o < per - 1) ? tb_code(p, s) : 3'b000, 1'b1, 1'b0, 1'b0, 3'(s)};
                end else if (r == d_cyc) begin
                    e = {3'b000, 1'b0, 1'b1, 1'b0, 3'(n - 1)};
                end else begin
                    e = {3'b000, 1'b0, 1'b0, 1'b0, 3'(n - 1)};
                end
            end
            chk(nm, r, outs(), e);
            if (done) begin
                n_done++;
                if (obs_done < 0) obs_done = r;
            end
            if (error && obs_err < 0) obs_err = r;
            if (r == mid_r) start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        chk_int({nm, " done_pulses"}, n_done, is_err ? 0 : 1);
        if (exp_done >= 0) chk_int({nm, " done_cycle"}, obs_done, exp_done);
        if (exp_err >= 0)  chk_int({nm, " err_cycle"}, obs_err, exp_err);
        if (exp_step >= 0) chk_int({nm, " final_step"}, int'(step), exp_step);
    endtask

    typedef struct {
        string nm;
        bit    p;
        bit    stk;
        int    lat;
        int    mid_r;
        int    exp_done;
        int    exp_err;
        int    exp_step;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{"full_l1",     1'b0, 1'b0, 1,  0,  37, -1, 5};
        tbl[1] = '{"short_l1",    1'b1, 1'b0, 1,  0,  25, -1, 3};
        tbl[2] = '{"stuck_full",  1'b0, 1'b1, 1,  0,  -1, 21, 0};
        tbl[3] = '{"recover",     1'b0, 1'b0, 1,  0,  37, -1, 5};
        tbl[4] = '{"restart_s2",  1'b0, 1'b0, 1,  14, 37, -1, 5};
        tbl[5] = '{"full_l8",     1'b0, 1'b0, 8,  0,  61, -1, 5};
        tbl[6] = '{"short_l19",   1'b1, 1'b0, 19, 0,  85, -1, 3};
        tbl[7] = '{"short_l20",   1'b1, 1'b0, 20, 0,  -1, 21, 0};

        reset = 1'b0;
        prep(1'b0, 1);
        @(negedge clk);
        chk("reset_state", 0, outs(), 11'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 0, outs(), 11'b0);

        for (int i = 0; i < 8; i++)
            run(tbl[i].nm, tbl[i].p, tbl[i].stk, tbl[i].lat, tbl[i].mid_r,
                tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_step);

        // Reset pulse while waiting for feedback on step 3 of the full path.
        prep(1'b0, 1);
        start = 1'b1; path_sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int r = 1; r < 23; r++) @(negedge clk);
        chk("pre_reset_wait_s3", 23, outs(), {3'b100, 1'b1, 1'b0, 1'b0, 3'd3});
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid_reset", 24, outs(), 11'b0);
        @(negedge clk);
        chk("post_reset_idle", 25, outs(), 11'b0);
        run("after_reset", 1'b0, 1'b0, 1, 0, 37, -1, 5);

        for (int k = 0; k < 12; k++) begin
            bit  p, stk;
            int  lat, mid;
            p   = 1'($urandom % 2);
            stk = ($urandom % 6) == 0;
            lat = int'($urandom_range(22, 1));
            mid = int'($urandom_range(20, 2));
            run("rand", p, stk, lat, mid, -1, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
